// File: rtl/alias_lane_merge_pkg.sv
// Shared types and helpers for the lane-merge block.
// Priority is lowest channel index first.
package alias_lane_merge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } ostate_e;

    function automatic int lane_count(int width, int lane_w);
        return width / lane_w;
    endfunction

    function automatic longint cnt_max(int cnt_w);
        return (longint'(1) << cnt_w) - 1;
    endfunction

    function automatic int lowest_set(logic [31:0] v);
        int r;
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/alias_lane_merge_if.sv
// Producer/consumer bundle for the lane-merge block.
// The producers and consumer sit on the master side.
interface alias_lane_merge_if #(
    parameter int WIDTH   = 16,
    parameter int NLANES  = 4,
    parameter int NCH     = 3,
    parameter int NMIRROR = 3
);
    logic [NCH-1:0]           ch_valid;
    logic [NCH*NLANES-1:0]    ch_lane_mask;
    logic [NCH*WIDTH-1:0]     ch_data;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [NMIRROR*WIDTH-1:0] mirror_o;

    modport master (
        output ch_valid, ch_lane_mask, ch_data, out_ready,
        input  in_ready, out_valid, mirror_o
    );

    modport slave (
        input  ch_valid, ch_lane_mask, ch_data, out_ready,
        output in_ready, out_valid, mirror_o
    );
endinterface

// File: rtl/alias_lane_merge_arbiter.sv
// Per-lane claim resolution: lowest claiming channel wins,
// two or more claims flag a conflict.
module alias_lane_arbiter
    import alias_lane_merge_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int LANE_W = 4
) (
    input  logic [NCH-1:0]        claim,
    input  logic [NCH*LANE_W-1:0] data,
    output logic [LANE_W-1:0]     win,
    output logic                  any_claim,
    output logic                  conflict
);
    int idx;

    always_comb begin
        idx       = lowest_set(32'(claim));
        win       = data[idx*LANE_W +: LANE_W];
        any_claim = |claim;
        conflict  = |(claim & (claim - NCH'(1)));
    end
endmodule

// File: rtl/alias_lane_merge.sv
// Multi-producer lane merge with conflict tracking and
// a replicated registered output word.
module alias_lane_merge
    import alias_lane_merge_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter int               LANE_W  = 4,
    parameter int               NCH     = 3,
    parameter int               NMIRROR = 3,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] INIT    = '0,
    localparam int              NLANES  = lane_count(WIDTH, LANE_W)
) (
    input  logic              clk,
    input  logic              rst,
    alias_lane_merge_if.slave bus,
    input  logic              clear_conflict,
    output logic [NLANES-1:0] conflict_lanes,
    output logic [CNT_W-1:0]  conflict_cnt
);
    localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));

    ostate_e            state;
    logic [WIDTH-1:0]   word;
    logic [LANE_W-1:0]  win [NLANES];
    logic [NLANES-1:0]  any_claim;
    logic [NLANES-1:0]  conf;
    logic               accept;
    logic               upd;
    logic               hit;

    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        logic [NCH-1:0]        claim;
        logic [NCH*LANE_W-1:0] ldata;
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            assign claim[c] = bus.ch_valid[c]
                            & bus.ch_lane_mask[c*NLANES + l];
            assign ldata[c*LANE_W +: LANE_W] =
                bus.ch_data[c*WIDTH + l*LANE_W +: LANE_W];
        end
        alias_lane_arbiter #(
            .NCH    (NCH),
            .LANE_W (LANE_W)
        ) u_arb (
            .claim     (claim),
            .data      (ldata),
            .win       (win[l]),
            .any_claim (any_claim[l]),
            .conflict  (conf[l])
        );
    end

    assign bus.out_valid = (state == HOLD);
    assign bus.in_ready  = !bus.out_valid || bus.out_ready;
    assign bus.mirror_o  = {NMIRROR{word}};
    assign accept        = bus.in_ready && (|bus.ch_valid);
    assign upd           = accept && (|any_claim);
    assign hit           = accept && (|conf);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            word           <= INIT;
            conflict_lanes <= '0;
            conflict_cnt   <= '0;
        end else begin
            for (int l = 0; l < NLANES; l++) begin
                if (accept && any_claim[l])
                    word[l*LANE_W +: LANE_W] <= win[l];
            end

            unique case (state)
                IDLE: if (upd) state <= HOLD;
                HOLD: if (bus.out_ready && !upd) state <= IDLE;
                default: state <= IDLE;
            endcase

            // A conflict landing with a clear survives the clear.
            if (clear_conflict) begin
                conflict_lanes <= hit ? conf : '0;
                conflict_cnt   <= hit ? CNT_W'(1) : '0;
            end else if (hit) begin
                conflict_lanes <= conflict_lanes | conf;
                if (conflict_cnt != CMAX)
                    conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end
endmodule
